// File: rtl/axi_ic_wr_arbiter.sv
// Round-robin write arbiter for one slave port: grants one master's AW+W burst at a
// time, tracks W beats against the captured AWLEN and flags WLAST mismatches.
module axi_ic_wr_arbiter #(
  parameter int NumMasters = 4
) (
  input  logic                  aclk,
  input  logic                  rst_n,
  input  logic [NumMasters-1:0] req_i,
  input  logic                  aw_hs_i,
  input  logic [7:0]            awlen_i,
  input  logic                  w_hs_i,
  input  logic                  wlast_i,
  output logic [((NumMasters > 1) ? $clog2(NumMasters) : 1)-1:0] grant_o,
  output logic                  aw_en_o,
  output logic                  w_en_o,
  output logic                  busy_o,
  output logic                  wlast_err_o
);

  localparam int GrantWidth = (NumMasters > 1) ? $clog2(NumMasters) : 1;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t                state, state_d;
  logic [GrantWidth-1:0] grant_d, last_grant, last_d, rr_win;
  logic [7:0]            awlen_q, awlen_d, beat_cnt, cnt_d;
  logic                  err_q, err_d, rr_found;

  // Search starts one past the last completed grant so every requester gets a turn.
  always_comb begin
    rr_win   = '0;
    rr_found = 1'b0;
    for (int i = 1; i <= NumMasters; i++) begin
      int idx;
      idx = (int'(last_grant) + i) % NumMasters;
      if (!rr_found && req_i[idx]) begin
        rr_found = 1'b1;
        rr_win   = GrantWidth'(idx);
      end
    end
  end

  always_comb begin
    state_d = state;
    grant_d = grant_o;
    last_d  = last_grant;
    awlen_d = awlen_q;
    cnt_d   = beat_cnt;
    err_d   = 1'b0;
    case (state)
      IDLE: if (rr_found) begin
        grant_d = rr_win;
        state_d = ADDR;
      end
      ADDR: if (aw_hs_i) begin
        awlen_d = awlen_i;
        cnt_d   = 8'd0;
        state_d = DATA;
        // A W beat accepted alongside AW is beat 0 of the new burst.
        if (w_hs_i) begin
          cnt_d = 8'd1;
          err_d = wlast_i != (awlen_i == 8'd0);
          if (wlast_i) begin
            state_d = IDLE;
            last_d  = grant_o;
          end
        end
      end
      DATA: if (w_hs_i) begin
        if (beat_cnt != 8'hff) cnt_d = beat_cnt + 8'd1;
        err_d = wlast_i != (beat_cnt == awlen_q);
        if (wlast_i) begin
          state_d = IDLE;
          last_d  = grant_o;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant_o    <= '0;
      last_grant <= GrantWidth'(NumMasters - 1);
      awlen_q    <= 8'd0;
      beat_cnt   <= 8'd0;
      err_q      <= 1'b0;
    end else begin
      state      <= state_d;
      grant_o    <= grant_d;
      last_grant <= last_d;
      awlen_q    <= awlen_d;
      beat_cnt   <= cnt_d;
      err_q      <= err_d;
    end
  end

  assign aw_en_o     = (state == ADDR);
  assign w_en_o      = (state != IDLE);
  assign busy_o      = (state != IDLE);
  assign wlast_err_o = err_q;

endmodule

// File: doc/axi_ic_wr_arbiter.md
AXI_IC_WR_ARBITER -- requirements
Module: axi_ic_wr_arbiter

Interface
REQ-001 The module SHALL have parameter NumMasters, default 4, giving the number of requesting masters for one slave port.
REQ-002 The module SHALL have localparam GrantWidth, equal to $clog2(NumMasters), or 1 when that is 0.
REQ-003 Port aclk, input, 1 bit: the interconnect clock.
REQ-004 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 Port req_i, input, NumMasters bits: bit m set means master m has AWVALID decoded to this slave.
REQ-006 Port aw_hs_i, input, 1 bit: AWVALID&&AWREADY on this slave's AW channel.
REQ-007 Port awlen_i, input, 8 bits: AWLEN of the granted master, valid when aw_hs_i is set.
REQ-008 Port w_hs_i, input, 1 bit: WVALID&&WREADY on this slave's W channel.
REQ-009 Port wlast_i, input, 1 bit: WLAST of the current W beat.
REQ-010 Port grant_o, output, GrantWidth bits: index of the granted master.
REQ-011 Port aw_en_o, output, 1 bit: routes AW of master grant_o to the slave.
REQ-012 Port w_en_o, output, 1 bit: routes W of master grant_o to the slave.
REQ-013 Port busy_o, output, 1 bit: a write transaction is in progress.
REQ-014 Port wlast_err_o, output, 1 bit: one-cycle pulse flagging a WLAST/AWLEN mismatch.

Function
REQ-015 FSM states SHALL be IDLE, ADDR and DATA; all outputs SHALL be registered or decoded from registered state only.
REQ-016 IDLE: if req_i is nonzero, the block SHALL load grant_o with the round-robin winner and move to ADDR on the next edge; otherwise it SHALL stay in IDLE.
REQ-017 Round-robin SHALL search from index last_grant+1 upward, wrapping modulo NumMasters.
REQ-018 last_grant SHALL update to grant_o only when a transaction completes.
REQ-019 ADDR: aw_en_o=1, w_en_o=1, busy_o=1; grant_o SHALL be held stable.
REQ-020 ADDR with aw_hs_i: the block SHALL capture awlen_i, clear beat_cnt and go to DATA.
REQ-021 ADDR with aw_hs_i and w_hs_i in the same cycle: the beat SHALL be counted as beat 0.
REQ-022 ADDR with aw_hs_i, w_hs_i and wlast_i all set: the block SHALL complete and return to IDLE directly.
REQ-023 ADDR without aw_hs_i: w_hs_i SHALL be ignored (not counted); the routed master may pre-send W data.
REQ-024 DATA: aw_en_o=0, w_en_o=1, busy_o=1; each w_hs_i SHALL increment the 8-bit beat_cnt, saturating at 255.
REQ-025 On each counted beat, expected_last SHALL be (beat_cnt == captured awlen).
REQ-026 If wlast_i != expected_last on a counted beat, wlast_err_o SHALL pulse high for exactly the next cycle.
REQ-027 A transaction SHALL complete only on a counted beat with wlast_i=1, regardless of any error.
REQ-028 On completion: last_grant<=grant_o, state<=IDLE, and aw_en_o, w_en_o and busy_o SHALL be 0 the next cycle.
REQ-029 The earliest re-grant SHALL be one cycle after completion, so back-to-back transactions have a minimum 1-cycle IDLE gap.
REQ-030 Changes on req_i SHALL not affect grant_o while in ADDR or DATA.
REQ-031 Latency from req_i assertion in IDLE to aw_en_o=1 SHALL be exactly 1 cycle.

Reset
REQ-032 On rst_n low, asynchronously: state=IDLE, grant_o=0, aw_en_o=0, w_en_o=0, busy_o=0, wlast_err_o=0, beat_cnt=0, captured awlen=0.
REQ-033 On rst_n low, last_grant SHALL be set to NumMasters-1, so that master 0 has first priority.
REQ-034 A reset asserted mid-transaction SHALL abort it with no completion or error pulse.
REQ-035 After rst_n deasserts, the first grant SHALL be possible on the first rising edge.

Verification
REQ-036 Reset, then req_i=4'b0101 held -> grant_o=0, aw_en_o=1 one cycle later; after completion the next grant is grant_o=2, and the one after that is 0.
REQ-037 Grant 1, aw_hs_i with awlen_i=3, then 4 w_hs_i beats with wlast_i only on the 4th -> no wlast_err_o pulse, busy_o=0 the cycle after the 4th beat.
REQ-038 awlen_i=0, with aw_hs_i, w_hs_i and wlast_i all in the same ADDR cycle -> next cycle state=IDLE, busy_o=0, wlast_err_o=0.
REQ-039 awlen_i=1, wlast_i on beat 0 -> wlast_err_o pulses for 1 cycle and the transaction completes.
REQ-040 awlen_i=1, no wlast_i on beat 1 -> wlast_err_o pulses and the block stays in DATA until a beat with wlast_i arrives.
REQ-041 rst_n pulsed low while in DATA with req_i=4'b1000 held -> all outputs 0 immediately, then grant_o=3 one cycle after release.
